tt_um_nithin574: RTL and testbench
==================================

Name: tt_um_nithin574

Overview:
Tiny Tapeout user-project top that detects the serial bit pattern 1-1-0-1-1 on ui_in[0] using a Mealy FSM.
Detection is non-overlapping: after a match the FSM restarts from idle.
Outputs are a combinational Mealy detect flag, a registered copy of it, the FSM state and a wrapping match counter, all on uo_out.
Sits directly under the TT harness; no sub-blocks outside this module.

Parameters:
- PATTERN, 5'b11011, target sequence; first-received bit is the MSB. Fixed; not user-overridden.
- CNT_W, 3, width of the match counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-high reset (rst_n=1 resets on the next rising edge). Name kept per harness convention.
- ena  input  1  design enable; when 0, all registers hold.
- ui_in  input  8  bit0 = serial data din; bits 7:1 unused.
- uio_in  input  8  unused.
- uo_out  output  8
  - bit0 = detect (Mealy, combinational)
  - bit1 = detect_q (detect registered)
  - bits4:2 = state code
  - bits7:5 = match count
- uio_out  output  8  constant 0.
- uio_oe  output  8  constant 0; all uio pins are inputs.

Behaviour:
- State encoding (3 bits):
  - S0=0: idle
  - S1=1: seen "1"
  - S2=2: seen "11"
  - S3=3: seen "110"
  - S4=4: seen "1101"
- Transitions, din=1 / din=0:
  - S0: S1 / S0
  - S1: S2 / S0
  - S2: S2 / S3 (a run of ones keeps "11")
  - S3: S4 / S0
  - S4: S0 with match / S0
- detect = ena & ~rst_n_active & (state==S4) & din. Purely combinational, zero latency: it is high in the same cycle the final 1 is presented.
- On a match:
  - next state is S0 (non-overlapping)
  - count increments by 1 mod 8; 7 wraps to 0
  - detect_q = 1 in the following cycle only
- detect_q <= detect every enabled cycle.
- Reset (rst_n=1 at a rising edge): state=S0, count=0, detect_q=0.
  - While reset is asserted, detect is forced to 0.
  - Reset takes priority over ena and mid-sequence progress; partial matches are discarded.
- ena=0: state, count and detect_q hold; detect forced to 0.
- Illegal state codes 5-7 go to S0 on the next enabled edge with no match.
- ui_in[7:1], uio_in: ignored; must not affect any output.
- Output values during reset:
  - uo_out = 8'h00
  - uio_out = 8'h00
  - uio_oe = 8'h00

Decomposition:
- Shared package holds:
  - the state enum/localparams S0..S4 and STATE_W=3
  - PATTERN
  - CNT_W
- One natural sub-module: seq_11011_fsm (state register, next-state logic, Mealy detect).
- The top adds the counter, the detect_q register and the pin mapping.

Test Plan:
- Reset, then din per clock 1,1,0,1,1 with ena=1 -> detect=1 only during the 5th cycle; state codes 1,2,3,4 then 0; detect_q=1 the next cycle; count=1.
- din 1,1,0,1,1,0,1,1 -> exactly one detect, at cycle 5. Cycles 6-8 reach S2, no second detect, which proves non-overlap; count=1.
- din 1,1,1,0,1,1 -> detect at cycle 6 (S2 self-loop on extra 1); din 1,1,0,0,1,1 -> no detect, state=2 at end.
- Each input bit held for 5 clocks (1,1,0,1,1,0,1,1,0,0,1,1) -> detect never asserts; count stays 0.
- Eight back-to-back 11011 patterns -> count steps 1..7 then wraps to 0.
- Assert rst_n=1 while in S4 with din=1 -> detect=0, count unchanged-then-cleared, state=0. A separate run with ena=0 mid-pattern shows state held and detect=0 until ena returns.

Source files
------------

// File: rtl/tt_um_nithin574_pkg.sv
// ============================================================================
// Module      : tt_um_nithin574_pkg
// Description : Shared state encoding and sizing for the 11011 detector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tt_um_nithin574_pkg;

    localparam int         STATE_W = 3;
    localparam int         CNT_W   = 3;
    localparam logic [4:0] PATTERN = 5'b11011;  // first-received bit is the MSB

    typedef enum logic [STATE_W-1:0] {
        S0 = 3'd0,  // idle
        S1 = 3'd1,  // seen "1"
        S2 = 3'd2,  // seen "11"
        S3 = 3'd3,  // seen "110"
        S4 = 3'd4   // seen "1101"
    } state_t;

endpackage

`default_nettype wire

// File: rtl/tt_um_nithin574_seq_11011_fsm.sv
// ============================================================================
// Module      : seq_11011_fsm
// Description : Non-overlapping Mealy detector for the serial pattern 11011.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_11011_fsm
    import tt_um_nithin574_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_ena,
    input  logic               i_din,
    output logic [STATE_W-1:0] o_state,
    output logic               o_detect
);

    state_t r_state;
    state_t w_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S0;
        end else if (i_ena) begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = S0;
        case (r_state)
            S0:      w_next = i_din ? S1 : S0;
            S1:      w_next = i_din ? S2 : S0;
            S2:      w_next = i_din ? S2 : S3;  // extra ones still leave "11" seen
            S3:      w_next = i_din ? S4 : S0;
            S4:      w_next = S0;               // match or miss, restart from idle
            default: w_next = S0;
        endcase
    end

    assign o_detect = i_ena & ~rst & (r_state == S4) & i_din;
    assign o_state  = r_state;

endmodule

`default_nettype wire

// File: rtl/tt_um_nithin574.sv
// ============================================================================
// Module      : tt_um_nithin574
// Description : Tiny Tapeout top: 11011 detector, registered flag, match count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tt_um_nithin574
    import tt_um_nithin574_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [STATE_W-1:0] w_state;
    logic               w_detect;
    logic               r_detect_q;
    logic [CNT_W-1:0]   r_count;

    // rst_n is active-high despite its harness-inherited name
    seq_11011_fsm u_fsm (
        .clk      (clk),
        .rst      (rst_n),
        .i_ena    (ena),
        .i_din    (ui_in[0]),
        .o_state  (w_state),
        .o_detect (w_detect)
    );

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_detect_q <= 1'b0;
            r_count    <= '0;
        end else if (ena) begin
            r_detect_q <= w_detect;
            if (w_detect) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign uo_out  = {r_count, w_state, r_detect_q, w_detect};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

    logic w_unused;
    assign w_unused = &{1'b0, ui_in[7:1], uio_in};

endmodule

`default_nettype wire

// File: tb/tb_tt_um_nithin574.sv
// ============================================================================
// Module      : tb_tt_um_nithin574
// Description : Scoreboard bench for the 11011 detector with a prefix-match model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tt_um_nithin574;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    typedef struct {
        string      tag;
        logic [7:0] exp;
        logic [7:0] mask;
    } exp_t;

    exp_t sb[$];
    int   n_assert;
    int   n_fail;
    int   m_state;
    int   m_cnt;
    bit   m_dq;

    tt_um_nithin574 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Longest prefix of 11011 that is a suffix of (matched prefix + new bit)
    function automatic int kmp(input int s, input bit d);
        logic [5:0] c;
        logic [4:0] pat;
        int         len;
        bit         ok;
        pat = 5'b11011;
        c   = '0;
        len = s + 1;
        for (int j = 0; j < s; j++) c[len-1-j] = pat[4-j];
        c[0] = d;
        for (int k = len; k > 0; k--) begin
            ok = 1'b1;
            for (int j = 0; j < k; j++)
                if (c[k-1-j] != pat[4-j]) ok = 1'b0;
            if (ok) return k;
        end
        return 0;
    endfunction

    task automatic check();
        exp_t e;
        if (sb.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL scoreboard_empty: observed 0 entries, expected at least 1");
        end else begin
            e = sb.pop_front();
            n_assert++;
            assert ((uo_out & e.mask) === (e.exp & e.mask)) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h (mask %h)",
                       e.tag, uo_out & e.mask, e.exp & e.mask, e.mask);
            end
        end
    endtask

    task automatic step(input bit din, input bit en, input bit r);
        bit m_det;
        @(negedge clk);
        rst_n  = r;
        ena    = en;
        ui_in  = {7'($urandom), din};
        uio_in = 8'($urandom);
        m_det  = en && !r && (m_state == 4) && din;
        sb.push_back('{"detect", {7'b0, m_det}, 8'h01});
        #1 check();
        if (r) begin
            m_state = 0;
            m_cnt   = 0;
            m_dq    = 1'b0;
        end else if (en) begin
            m_dq = m_det;
            if (m_det) begin
                m_cnt   = (m_cnt + 1) % 8;
                m_state = 0;
            end else begin
                m_state = kmp(m_state, din);
            end
        end
        sb.push_back('{r ? "reset_out" : "regs",
                       {m_cnt[2:0], m_state[2:0], m_dq, 1'b0},
                       r ? 8'hFF : 8'hFE});
        @(posedge clk);
        #1 check();
    endtask

    task automatic do_reset();
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        n_assert++;
        assert ({uio_out, uio_oe} === 16'h0000) else begin
            n_fail++;
            $error("FAIL uio_const: observed %h expected 0000", {uio_out, uio_oe});
        end
    endtask

    task automatic seq(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) step(bits[i], 1'b1, 1'b0);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        m_state  = 0;
        m_cnt    = 0;
        m_dq     = 1'b0;
        rst_n    = 1'b1;
        ena      = 1'b0;
        ui_in    = 8'h00;
        uio_in   = 8'h00;

        do_reset();
        seq(32'b110110, 6);

        do_reset();
        seq(32'b11011011, 8);

        do_reset();
        seq(32'b111011, 6);
        do_reset();
        seq(32'b110011, 6);

        do_reset();
        begin
            logic [11:0] slow;
            slow = 12'b110110110011;
            for (int i = 11; i >= 0; i--)
                for (int k = 0; k < 5; k++) step(slow[i], 1'b1, 1'b0);
        end

        do_reset();
        for (int p = 0; p < 8; p++) seq(32'b11011, 5);

        do_reset();
        seq(32'b11011, 5);
        seq(32'b1101, 4);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);

        do_reset();
        seq(32'b11, 2);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        seq(32'b011, 3);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
